// File: rtl/arb_pkg.sv
// ============================================================================
// Module      : arb_pkg
// Description : Shared constants and types for the rr_arbiter8 block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package arb_pkg;

    localparam int N_REQ       = 8;
    localparam int IDX_W       = 3;
    localparam int TIMEOUT_CYC = 16;
    localparam int CNT_W       = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    typedef logic [N_REQ-1:0] req_vec_t;
    typedef logic [IDX_W-1:0] idx_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter8_if.sv
// ============================================================================
// Module      : rr_arbiter8_if
// Description : Request/grant bundle between the requester array and arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rr_arbiter8_if;
    import arb_pkg::*;

    req_vec_t req;
    logic     rel;
    req_vec_t gnt;
    idx_t     gnt_idx;
    logic     gnt_vld;
    logic     timeout;

    modport master (
        output req, rel,
        input  gnt, gnt_idx, gnt_vld, timeout
    );

    modport slave (
        input  req, rel,
        output gnt, gnt_idx, gnt_vld, timeout
    );

endinterface

`default_nettype wire

// File: rtl/rr_pick8.sv
// ============================================================================
// Module      : rr_pick8
// Description : Rotating-start 8:3 priority pick (combinational).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick8
    import arb_pkg::*;
(
    input  req_vec_t req,
    input  idx_t     ptr,
    output idx_t     pick_idx,
    output logic     pick_vld
);

    req_vec_t rot_w;
    idx_t     src_w;
    idx_t     enc_w;

    // Rotate right by ptr so that requester ptr lands on bit 0.
    always_comb begin
        rot_w = '0;
        src_w = '0;
        for (int k = 0; k < N_REQ; k++) begin
            src_w    = idx_t'(k) + ptr;
            rot_w[k] = req[src_w];
        end
    end

    always_comb begin
        enc_w = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot_w[k]) begin
                enc_w = idx_t'(k);
            end
        end
    end

    assign pick_vld = |req;
    assign pick_idx = enc_w + ptr;

endmodule

`default_nettype wire

// File: rtl/rr_arbiter8.sv
// ============================================================================
// Module      : rr_arbiter8
// Description : 8-way round-robin arbiter with registered, held grants.
//               Optional forced release enabled by macro ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter8
    import arb_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    rr_arbiter8_if.slave   bus
);

    state_t   state_q,   state_d;
    req_vec_t gnt_q,     gnt_d;
    idx_t     gnt_idx_q, gnt_idx_d;
    logic     gnt_vld_q, gnt_vld_d;
    idx_t     ptr_q,     ptr_d;

    idx_t     pick_idx;
    logic     pick_vld;
    logic     rel_evt;

`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             timeout_q,  timeout_d;
`endif

    rr_pick8 u_pick (
        .req      (bus.req),
        .ptr      (ptr_q),
        .pick_idx (pick_idx),
        .pick_vld (pick_vld)
    );

    // Dropping the owner's request is an abandon and counts as a release.
    assign rel_evt = bus.rel | ~bus.req[gnt_idx_q];

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_idx_d = gnt_idx_q;
        gnt_vld_d = gnt_vld_q;
        ptr_d     = ptr_q;
`ifdef ARB_TIMEOUT_EN
        hold_cnt_d = hold_cnt_q;
        timeout_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    gnt_d     = req_vec_t'(1) << pick_idx;
                    gnt_idx_d = pick_idx;
                    gnt_vld_d = 1'b1;
                    state_d   = BUSY;
`ifdef ARB_TIMEOUT_EN
                    hold_cnt_d = '0;
`endif
                end
            end
            BUSY: begin
                if (rel_evt) begin
                    gnt_d     = '0;
                    gnt_vld_d = 1'b0;
                    ptr_d     = gnt_idx_q + idx_t'(1);
                    state_d   = IDLE;
                end
`ifdef ARB_TIMEOUT_EN
                // Counter value TIMEOUT_CYC-1 marks the last permitted visible cycle.
                else if (hold_cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    gnt_d     = '0;
                    gnt_vld_d = 1'b0;
                    ptr_d     = gnt_idx_q + idx_t'(1);
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            gnt_idx_q <= '0;
            gnt_vld_q <= 1'b0;
            ptr_q     <= '0;
`ifdef ARB_TIMEOUT_EN
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_idx_q <= gnt_idx_d;
            gnt_vld_q <= gnt_vld_d;
            ptr_q     <= ptr_d;
`ifdef ARB_TIMEOUT_EN
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
`endif
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.gnt_idx = gnt_idx_q;
    assign bus.gnt_vld = gnt_vld_q;
`ifdef ARB_TIMEOUT_EN
    assign bus.timeout = timeout_q;
`else
    assign bus.timeout = 1'b0;
`endif

endmodule

`default_nettype wire
